// File: rtl/axi_arb_wrr_slice_if.sv
// Request-side and output-side bundle of the weighted round-robin arbiter.
// master drives requests/config/downstream grant; slave is the arbiter.
interface axi_arb_wrr_slice_if #(
   parameter int AUX_WIDTH    = 64,
   parameter int ID_WIDTH     = 20,
   parameter int N_MASTER     = 5,
   parameter int LOG_MASTER   = $clog2(N_MASTER),
   parameter int WEIGHT_WIDTH = 4
);
   logic [N_MASTER-1:0]              data_req_i;
   logic [N_MASTER*AUX_WIDTH-1:0]    data_AUX_i;
   logic [N_MASTER*ID_WIDTH-1:0]     data_ID_i;
   logic [N_MASTER-1:0]              data_gnt_o;
   logic [N_MASTER*WEIGHT_WIDTH-1:0] weight_i;
   logic                             lock;
   logic [LOG_MASTER-1:0]            SEL_EXCLUSIVE;
   logic                             data_req_o;
   logic [AUX_WIDTH-1:0]             data_AUX_o;
   logic [ID_WIDTH-1:0]              data_ID_o;
   logic                             data_gnt_i;
   logic [LOG_MASTER-1:0]            grant_idx_o;

   modport master (
      output data_req_i, data_AUX_i, data_ID_i, weight_i,
      output lock, SEL_EXCLUSIVE, data_gnt_i,
      input  data_gnt_o, data_req_o, data_AUX_o, data_ID_o,
      input  grant_idx_o
   );

   modport slave (
      input  data_req_i, data_AUX_i, data_ID_i, weight_i,
      input  lock, SEL_EXCLUSIVE, data_gnt_i,
      output data_gnt_o, data_req_o, data_AUX_o, data_ID_o,
      output grant_idx_o
   );
endinterface

// File: rtl/axi_arb_wrr_slice.sv
// Weighted round-robin N-to-1 request arbiter with exclusive lock steering.
// Define AXI_ARB_OUT_REG_EN for a registered output stage (default: pass-through).
module axi_arb_wrr_slice #(
   parameter int AUX_WIDTH    = 64,
   parameter int ID_WIDTH     = 20,
   parameter int N_MASTER     = 5,
   parameter int LOG_MASTER   = $clog2(N_MASTER),
   parameter int WEIGHT_WIDTH = 4
) (
   input logic                clk,
   input logic                rst_n,
   axi_arb_wrr_slice_if.slave bus
);

   localparam logic [LOG_MASTER:0]   NM   = (LOG_MASTER+1)'(N_MASTER);
   localparam logic [LOG_MASTER-1:0] LAST = LOG_MASTER'(N_MASTER-1);

   logic [AUX_WIDTH-1:0]    aux  [N_MASTER];
   logic [ID_WIDTH-1:0]     id   [N_MASTER];
   logic [WEIGHT_WIDTH-1:0] wt   [N_MASTER];
   logic [N_MASTER-1:0]     elig;

   logic [LOG_MASTER-1:0]   ptr_q, ptr_d;
   logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;

   logic [LOG_MASTER:0]     sum;
   logic [LOG_MASTER-1:0]   cand;
   logic [LOG_MASTER-1:0]   win;
   logic                    any;
   logic                    acc;
   logic                    fire;
   logic [WEIGHT_WIDTH-1:0] wt_w;

   always_comb begin
      for (int i = 0; i < N_MASTER; i++) begin
         aux[i]  = bus.data_AUX_i[i*AUX_WIDTH +: AUX_WIDTH];
         id[i]   = bus.data_ID_i[i*ID_WIDTH +: ID_WIDTH];
         wt[i]   = bus.weight_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         elig[i] = bus.data_req_i[i] &&
                   (!bus.lock ||
                    bus.SEL_EXCLUSIVE == LOG_MASTER'(i));
      end
   end

   // rotate the search start to ptr_q, wrapping at N_MASTER
   always_comb begin
      win  = '0;
      any  = 1'b0;
      sum  = '0;
      cand = '0;
      for (int k = 0; k < N_MASTER; k++) begin
         sum = {1'b0, ptr_q} + (LOG_MASTER+1)'(k);
         if (sum >= NM) sum = sum - NM;
         cand = sum[LOG_MASTER-1:0];
         if (!any && elig[cand]) begin
            win = cand;
            any = 1'b1;
         end
      end
   end

   assign wt_w = wt[win];

`ifdef AXI_ARB_OUT_REG_EN
   logic                  req_q, req_d;
   logic [AUX_WIDTH-1:0]  aux_q, aux_d;
   logic [ID_WIDTH-1:0]   id_q,  id_d;
   logic [LOG_MASTER-1:0] idx_q, idx_d;

   assign acc = !req_q || bus.data_gnt_i;

   always_comb begin
      req_d = req_q;
      aux_d = aux_q;
      id_d  = id_q;
      idx_d = idx_q;
      if (acc) begin
         req_d = any;
         if (any) begin
            aux_d = aux[win];
            id_d  = id[win];
            idx_d = win;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= 1'b0;
         aux_q <= '0;
         id_q  <= '0;
         idx_q <= '0;
      end else begin
         req_q <= req_d;
         aux_q <= aux_d;
         id_q  <= id_d;
         idx_q <= idx_d;
      end
   end

   assign bus.data_req_o  = req_q;
   assign bus.data_AUX_o  = aux_q;
   assign bus.data_ID_o   = id_q;
   assign bus.grant_idx_o = idx_q;
`else
   logic out_vld;

   assign acc     = bus.data_gnt_i;
   assign out_vld = rst_n && any;

   assign bus.data_req_o  = out_vld;
   assign bus.data_AUX_o  = out_vld ? aux[win] : '0;
   assign bus.data_ID_o   = out_vld ? id[win]  : '0;
   assign bus.grant_idx_o = out_vld ? win      : '0;
`endif

   // no grant while reset is held, even though the grant path is combinational
   assign fire = rst_n && any && acc;

   assign bus.data_gnt_o = fire ? (N_MASTER'(1) << win) : '0;

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (fire && !bus.lock) begin
         if (win == ptr_q && cnt_q < wt_w) begin
            cnt_d = cnt_q + 1'b1;
         end else if (win != ptr_q && wt_w != '0) begin
            ptr_d = win;
            cnt_d = WEIGHT_WIDTH'(1);
         end else begin
            ptr_d = (win == LAST) ? '0 : win + 1'b1;
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule
